// File: rtl/ddr4_axi_ctrl_int_wr_arb_if.sv
// rtl/ddr4_axi_ctrl_int_wr_arb_if.sv - internal write arbiter bus bundle
//
// Groups the requester handshake, external-write snoop and internal write
// port of ddr4_axi_ctrl_int_wr_arb.
//   master : producers / register-bank side (drives requests and ext write)
//   slave  : the arbiter (drives req_ready and the internal write port)
// Signals:
//   arb_en                      grant enable
//   req_valid/req_addr/req_data packed per-requester write requests
//   req_ready                   one-hot combinational accept
//   ext_we/ext_addr             external AXI-Lite write seen this cycle
//   int_we/int_addr/int_data    registered internal write
//   int_drop                    registered overridden-write pulse
//   coll_cnt                    collision count
interface ddr4_axi_ctrl_int_wr_arb_if #(
  parameter int C_NUM_REQ    = 4,
  parameter int C_REG_WIDTH  = 32,
  parameter int C_ADDR_WIDTH = 4
);
  logic                              arb_en;
  logic [C_NUM_REQ-1:0]              req_valid;
  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr;
  logic [C_NUM_REQ*C_REG_WIDTH-1:0]  req_data;
  logic [C_NUM_REQ-1:0]              req_ready;
  logic                              ext_we;
  logic [C_ADDR_WIDTH-1:0]           ext_addr;
  logic                              int_we;
  logic [C_ADDR_WIDTH-1:0]           int_addr;
  logic [C_REG_WIDTH-1:0]            int_data;
  logic                              int_drop;
  logic [15:0]                       coll_cnt;

  modport master (
    output arb_en, req_valid, req_addr, req_data, ext_we, ext_addr,
    input  req_ready, int_we, int_addr, int_data, int_drop, coll_cnt
  );

  modport slave (
    input  arb_en, req_valid, req_addr, req_data, ext_we, ext_addr,
    output req_ready, int_we, int_addr, int_data, int_drop, coll_cnt
  );
endinterface

// File: rtl/ddr4_axi_ctrl_int_wr_arb.sv
// rtl/ddr4_axi_ctrl_int_wr_arb.sv - round-robin arbiter for the internal register write port
//
// Shares the register bank's internal write port among C_NUM_REQ status
// producers, issuing one registered write per cycle, and flags internal
// writes that collide with a same-cycle external write to the same index.
// Ports:
//   clk    single clock
//   reset  asynchronous active-high reset
//   bus    ddr4_axi_ctrl_int_wr_arb_if.slave (requests, ext snoop, write port)
// Build option:
//   DDR4_AXI_CTRL_ARB_COLL_CNT_EN  enables the saturating 16-bit collision
//                                  counter; otherwise coll_cnt reads 0.
module ddr4_axi_ctrl_int_wr_arb #(
  parameter int C_NUM_REQ    = 4,
  parameter int C_REG_WIDTH  = 32,
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  ddr4_axi_ctrl_int_wr_arb_if.slave        bus
);

  localparam int IDX_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        winner;
  logic [CW-1:0]           cand;
  logic                    found;
  logic                    accept;
  logic                    collision;
  logic [C_NUM_REQ-1:0]    ready;
  logic [C_ADDR_WIDTH-1:0] win_addr;
  logic [C_REG_WIDTH-1:0]  win_data;
  logic [C_ADDR_WIDTH-1:0] int_addr_q;
  logic [C_REG_WIDTH-1:0]  int_data_q;
  logic                    int_drop_q;

  // Search upward from rr_ptr with wrap; cand is one bit wider so that
  // rr_ptr + k never overflows before the modulo subtraction.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(C_NUM_REQ)) begin
        cand = cand - CW'(C_NUM_REQ);
      end
      if (!found && bus.req_valid[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign accept = bus.arb_en & found;

  always_comb begin
    ready    = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        ready[i] = accept;
        win_addr = bus.req_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        win_data = bus.req_data[i*C_REG_WIDTH +: C_REG_WIDTH];
      end
    end
  end

  // The external write always wins in the register bank, so an internal
  // write to the same index in the same cycle is lost.
  assign collision = (state == ISSUE) & bus.ext_we & (bus.ext_addr == int_addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      int_addr_q <= '0;
      int_data_q <= '0;
      int_drop_q <= 1'b0;
    end else begin
      int_drop_q <= collision;
      case (state)
        IDLE, ISSUE: begin
          if (accept) begin
            state      <= ISSUE;
            int_addr_q <= win_addr;
            int_data_q <= win_data;
            rr_ptr     <= (winner == IDX_W'(C_NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR4_AXI_CTRL_ARB_COLL_CNT_EN
  logic [15:0] coll_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_cnt_q <= 16'h0000;
    end else if (collision && (coll_cnt_q != 16'hFFFF)) begin
      coll_cnt_q <= coll_cnt_q + 16'd1;
    end
  end

  assign bus.coll_cnt = coll_cnt_q;
`else
  assign bus.coll_cnt = 16'h0000;
`endif

  assign bus.req_ready = ready;
  assign bus.int_we    = (state == ISSUE);
  assign bus.int_addr  = int_addr_q;
  assign bus.int_data  = int_data_q;
  assign bus.int_drop  = int_drop_q;

endmodule
